// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding and the ALU arbiter state type.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XNOR  = 4'b0111;
  localparam logic [3:0] OP_SLEEP = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the shared ALU arbiter; zero/carry exist only with ALU_FLAGS_EN.
interface alu_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4
) ();

  logic [NREQ-1:0]       req;
  logic [4*NREQ-1:0]     op_in;
  logic [WIDTH*NREQ-1:0] a_in;
  logic [WIDTH*NREQ-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic                  busy;
`ifdef ALU_FLAGS_EN
  logic                  zero;
  logic                  carry;

  modport master (output req, op_in, a_in, b_in,
                  input  gnt, done, result, busy, zero, carry);
  modport slave  (input  req, op_in, a_in, b_in,
                  output gnt, done, result, busy, zero, carry);
`else
  modport master (output req, op_in, a_in, b_in,
                  input  gnt, done, result, busy);
  modport slave  (input  req, op_in, a_in, b_in,
                  output gnt, done, result, busy);
`endif

endinterface

// File: rtl/alu_core.sv
// Combinational 4-bit-opcode ALU shared by the CPU core and the arbiter.
// ALU_FLAGS_EN adds the carry/borrow output.
module alu_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry
`endif
);

  // Result select; unsupported opcodes yield zero.
  always_comb begin
    y = {WIDTH{1'b0}};
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XNOR: y = ~(a ^ b);
      default: y = {WIDTH{1'b0}};
    endcase
  end

`ifdef ALU_FLAGS_EN
  // An ADD wrapped exactly when its truncated sum drops below an operand.
  always_comb begin
    carry = 1'b0;
    case (op)
      OP_ADD:  carry = (y < a);
      OP_SUB:  carry = (a < b);
      default: carry = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_core between NREQ requesters (IDLE/EXEC/RESP).
// Optional macro ALU_FLAGS_EN adds registered zero/carry flags.
module alu_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       state_r;
  logic [IW-1:0]    rr_ptr_r;
  logic [IW-1:0]    win_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [NREQ-1:0]  gnt_r;
  logic [NREQ-1:0]  done_r;
  logic [WIDTH-1:0] result_r;
  logic             busy_r;

  logic [IW-1:0]    pick_s;
  logic [IW-1:0]    cand_s;
  logic             take_s;
  logic             found_s;
  logic [WIDTH-1:0] alu_y_s;
`ifdef ALU_FLAGS_EN
  logic             alu_carry_s;
  logic             zero_r;
  logic             carry_r;
`endif

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op (op_r),
    .a  (a_r),
    .b  (b_r),
    .y  (alu_y_s)
`ifdef ALU_FLAGS_EN
    ,
    .carry (alu_carry_s)
`endif
  );

  // First requesting index at or above rr_ptr, wrapping past NREQ-1.
  always_comb begin
    found_s = 1'b0;
    pick_s  = rr_ptr_r;
    cand_s  = rr_ptr_r;
    take_s  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s  = IW'((int'(rr_ptr_r) + k) % NREQ);
      take_s  = !found_s && bus.req[cand_s];
      pick_s  = take_s ? cand_s : pick_s;
      found_s = found_s | take_s;
    end
  end

  // Arbitration FSM with operand latch and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      rr_ptr_r <= {IW{1'b0}};
      win_r    <= {IW{1'b0}};
      op_r     <= 4'b0000;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      gnt_r    <= {NREQ{1'b0}};
      done_r   <= {NREQ{1'b0}};
      result_r <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero_r   <= 1'b0;
      carry_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            win_r   <= pick_s;
            op_r    <= bus.op_in[4*int'(pick_s) +: 4];
            a_r     <= bus.a_in[WIDTH*int'(pick_s) +: WIDTH];
            b_r     <= bus.b_in[WIDTH*int'(pick_s) +: WIDTH];
            gnt_r   <= NREQ'(1'b1) << pick_s;
            busy_r  <= 1'b1;
            state_r <= EXEC;
          end
        end
        EXEC: begin
          result_r <= alu_y_s;
          done_r   <= NREQ'(1'b1) << win_r;
`ifdef ALU_FLAGS_EN
          zero_r   <= (alu_y_s == {WIDTH{1'b0}});
          carry_r  <= alu_carry_s;
`endif
          state_r  <= RESP;
        end
        RESP: begin
          // The extra cycle keeps a still-high req of the finished winner from re-arbitrating.
          done_r   <= {NREQ{1'b0}};
          gnt_r    <= {NREQ{1'b0}};
          busy_r   <= 1'b0;
          rr_ptr_r <= IW'((int'(win_r) + 1) % NREQ);
          state_r  <= IDLE;
        end
        default: begin
          done_r  <= {NREQ{1'b0}};
          gnt_r   <= {NREQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.busy   = busy_r;
`ifdef ALU_FLAGS_EN
  assign bus.zero   = zero_r;
  assign bus.carry  = carry_r;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter against a transaction-level round-robin/ALU model.
module tb_alu_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks    = 0;
  int n_pass      = 0;
  int ptr         = 0;
  int last_result = 0;
  int op_v [NREQ];
  int a_v  [NREQ];
  int b_v  [NREQ];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      2:       return (a + b) & MASK;
      3:       return (a - b) & MASK;
      4:       return a & b;
      5:       return a | b;
      7:       return (~(a ^ b)) & MASK;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_carry(input int op, input int a, input int b);
    if (op == 2) return ((a + b) > MASK) ? 1 : 0;
    if (op == 3) return (a < b) ? 1 : 0;
    return 0;
  endfunction

  function automatic int ref_winner(input int mask);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.op_in[4*i +: 4]         = 4'(op_v[i]);
      bus.a_in[WIDTH*i +: WIDTH]  = WIDTH'(a_v[i]);
      bus.b_in[WIDTH*i +: WIDTH]  = WIDTH'(b_v[i]);
    end
  endtask

  task automatic scramble_bus();
    for (int i = 0; i < NREQ; i++) begin
      bus.op_in[4*i +: 4]         = 4'($urandom_range(0, 15));
      bus.a_in[WIDTH*i +: WIDTH]  = WIDTH'($urandom_range(0, MASK));
      bus.b_in[WIDTH*i +: WIDTH]  = WIDTH'($urandom_range(0, MASK));
    end
  endtask

  task automatic set_op(input int r, input int op, input int a, input int b);
    op_v[r] = op;
    a_v[r]  = a;
    b_v[r]  = b;
  endtask

  // One complete transaction, entered and left at a negedge with the DUT idle.
  task automatic txn(input int mask, input string tag);
    int w, exp_y, exp_c;
    bus.req = NREQ'(mask);
    drive_ops();
    w     = ref_winner(mask);
    exp_y = ref_alu(op_v[w], a_v[w], b_v[w]);
    exp_c = ref_carry(op_v[w], a_v[w], b_v[w]);
    @(negedge clk);
    check_eq({tag, ".gnt"},       int'(bus.gnt),    1 << w);
    check_eq({tag, ".busy"},      int'(bus.busy),   1);
    check_eq({tag, ".done_early"},int'(bus.done),   0);
    check_eq({tag, ".res_hold"},  int'(bus.result), last_result);
    scramble_bus();
    @(negedge clk);
    check_eq({tag, ".done"},      int'(bus.done),   1 << w);
    check_eq({tag, ".result"},    int'(bus.result), exp_y);
    check_eq({tag, ".gnt_held"},  int'(bus.gnt),    1 << w);
`ifdef ALU_FLAGS_EN
    check_eq({tag, ".zero"},      int'(bus.zero),   (exp_y == 0) ? 1 : 0);
    check_eq({tag, ".carry"},     int'(bus.carry),  exp_c);
`endif
    bus.req = {NREQ{1'b0}};
    drive_ops();
    @(negedge clk);
    check_eq({tag, ".gnt_off"},   int'(bus.gnt),    0);
    check_eq({tag, ".done_off"},  int'(bus.done),   0);
    check_eq({tag, ".busy_off"},  int'(bus.busy),   0);
    check_eq({tag, ".res_kept"},  int'(bus.result), exp_y);
    last_result = exp_y;
    ptr         = (w + 1) % NREQ;
  endtask

  task automatic do_reset(input string tag);
    reset   = 1'b0;
    bus.req = {NREQ{1'b1}};
    repeat (2) begin
      @(negedge clk);
      check_eq({tag, ".gnt"},    int'(bus.gnt),    0);
      check_eq({tag, ".done"},   int'(bus.done),   0);
      check_eq({tag, ".result"}, int'(bus.result), 0);
      check_eq({tag, ".busy"},   int'(bus.busy),   0);
    end
    bus.req     = {NREQ{1'b0}};
    reset       = 1'b1;
    ptr         = 0;
    last_result = 0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_op(i, 0, 0, 0);
    bus.req = {NREQ{1'b1}};
    drive_ops();
    @(posedge clk);
    do_reset("reset");

    set_op(0, 2, 5, 3);
    txn(1, "single");

    do_reset("reset2");
    set_op(0, 2, 1, 1);
    set_op(1, 3, 2, 3);
    for (int t = 0; t < 4; t++) txn(3, $sformatf("contend%0d", t));

    begin
      int dir_op [5] = '{2, 7, 4, 5, 8};
      int dir_a  [5] = '{9, 10, 12, 12, 7};
      int dir_b  [5] = '{8, 5, 10, 3, 6};
      for (int t = 0; t < 5; t++) begin
        int r;
        r = $urandom_range(0, NREQ - 1);
        set_op(r, dir_op[t], dir_a[t], dir_b[t]);
        txn(1 << r, $sformatf("dirop%0d", t));
      end
    end

    // Leave the pointer at 1, then abandon a transaction from requester 1 in EXEC.
    set_op(0, 2, 1, 2);
    set_op(1, 4, 15, 15);
    txn(1, "pre_abort");
    bus.req = NREQ'(2);
    @(negedge clk);
    check_eq("abort.gnt", int'(bus.gnt), 2);
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort.done", int'(bus.done), 0);
    check_eq("abort.gnt_off", int'(bus.gnt), 0);
    check_eq("abort.busy", int'(bus.busy), 0);
    check_eq("abort.result", int'(bus.result), 0);
    reset       = 1'b1;
    bus.req     = {NREQ{1'b0}};
    ptr         = 0;
    last_result = 0;
    @(negedge clk);
    check_eq("abort.no_late_done", int'(bus.done), 0);
    txn(3, "post_abort_both");
    txn(2, "post_abort_req1");

`ifdef ALU_FLAGS_EN
    set_op(0, 3, 3, 3);
    txn(1, "flag_sub0");
    set_op(1, 2, 15, 1);
    txn(2, "flag_addc");
    set_op(0, 3, 2, 3);
    txn(1, "flag_borrow");
`endif

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++)
        set_op(i, $urandom_range(0, 15), $urandom_range(0, MASK), $urandom_range(0, MASK));
      txn($urandom_range(1, (1 << NREQ) - 1), $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
